// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin over WIDTH bits, SLICE bits per clock, LSB first.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r, b_r, partial_r;
  logic             busy_r, done_r, cout_r;
  logic [WIDTH-1:0] sum_r;
  logic             accept_s, last_s;
  logic [SLICE-1:0] slice_a_s, slice_b_s, slice_sum_s;
  logic             slice_cout_s;
  logic [WIDTH-1:0] merged_s;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_r, ovf_s;
`endif

  // Ripple of SLICE full-adder cells on the current slice, seeded by the stored carry.
  always_comb begin : slice_add
    logic c;
`ifdef SERIAL_ADDER_OVF_EN
    logic c_msb;
    c_msb = carry_r;
`endif
    slice_a_s   = a_r[cnt_r*SLICE +: SLICE];
    slice_b_s   = b_r[cnt_r*SLICE +: SLICE];
    slice_sum_s = '0;
    c           = carry_r;
    for (int i = 0; i < SLICE; i++) begin
`ifdef SERIAL_ADDER_OVF_EN
      c_msb = c;
`endif
      slice_sum_s[i] = slice_a_s[i] ^ slice_b_s[i] ^ c;
      c = (slice_a_s[i] & slice_b_s[i]) | (c & (slice_a_s[i] ^ slice_b_s[i]));
    end
    slice_cout_s = c;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_s = c_msb ^ c;
`endif
    merged_s = partial_r;
    merged_s[cnt_r*SLICE +: SLICE] = slice_sum_s;
  end

  // Next-state logic: accept in IDLE, finish after the last slice.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST) begin
          state_nxt_s = IDLE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs; rst dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      partial_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= last_s;
      if (accept_s) begin
        a_r       <= a;
        b_r       <= b;
        carry_r   <= cin;
        cnt_r     <= '0;
        partial_r <= '0;
      end else if (state_r == RUN) begin
        partial_r <= merged_s;
        carry_r   <= slice_cout_s;
        cnt_r     <= cnt_r + CW'(1);
      end
      // Results move only on the completing edge so they stay stable during RUN.
      if (last_s) begin
        sum_r  <= merged_s;
        cout_r <= slice_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_r  <= ovf_s;
`endif
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule
